// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder and its controller.
package serial_adder_pkg;

  localparam int unsigned ADDER_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/sum_deserializer.sv
// Right-shifting SIPO collecting serial sum bits, plus final carry capture.
module sum_deserializer
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             last,
  input  logic             sum_bit,
  input  logic             carry_bit,
  output logic [WIDTH-1:0] result,
  output logic             carry_o
);

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;

  // Next value: clear, shift sum bit in at the MSB, grab carry on the last shift
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    if (clr) begin
      result_d = '0;
      carry_d  = 1'b0;
    end else if (shift_en) begin
      result_d = {sum_bit, result_q[WIDTH-1:1]};
      if (last) begin
        carry_d = carry_bit;
      end
    end
  end

  // Result and carry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign result  = result_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequencer for the bit-serial adder: operand handshake, adder control, result handshake.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_o,
  output logic             adder_rst,
  output logic             load_a,
  output logic             load_b,
  output logic             enable,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b,
  input  logic             sum_bit,
  input  logic             carry_bit
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_a_q, data_a_d;
  logic [WIDTH-1:0] data_b_q, data_b_d;
  logic             shift_last;

  // Next-state, counter and operand latch logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_a_d = op_a;
          data_b_d = op_b;
          state_d  = CLR;
        end
      end
      CLR:  state_d = LOAD;
      LOAD: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign shift_last = (state_q == SHIFT) && (cnt_q == LAST);

  sum_deserializer #(
    .WIDTH(WIDTH)
  ) u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == LOAD),
    .shift_en (state_q == SHIFT),
    .last     (shift_last),
    .sum_bit  (sum_bit),
    .carry_bit(carry_bit),
    .result   (result),
    .carry_o  (carry_o)
  );

  // Control outputs are plain decodes of the registered state; adder_rst also
  // follows rst_n directly so the adder is cleared while we are held in reset.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign load_a    = (state_q == LOAD);
  assign load_b    = (state_q == LOAD);
  assign enable    = (state_q == SHIFT);
  assign adder_rst = ~rst_n | (state_q == CLR);
  assign data_a    = data_a_q;
  assign data_b    = data_b_q;

endmodule
